// File: rtl/clock_and_reset_pkg.sv
// Shared types and default widths for the clock-cycle-counting timer.
package clock_and_reset_pkg;
  typedef enum logic {IDLE, COUNT} ccount_state_e;
  localparam int CCOUNT_CNT_W = 32;
  localparam int CCOUNT_EXP_W = 16;
endpackage

// File: rtl/cycle_count_timer_if.sv
// Command handshake bundle: requester drives count/abort, timer answers with ready.
interface cycle_count_timer_if #(
  parameter int CNT_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_abort;

  modport master (output cmd_valid, cmd_count, cmd_abort, input cmd_ready);
  modport slave  (input cmd_valid, cmd_count, cmd_abort, output cmd_ready);
endinterface

// File: rtl/cycle_count_timer.sv
// Down-counting timeout engine with a one-deep command slot, expiry pulse
// and saturating completion counter.
module cycle_count_timer
  import clock_and_reset_pkg::*;
#(
  parameter int CNT_W = CCOUNT_CNT_W,
  parameter int EXP_W = CCOUNT_EXP_W
) (
  input  logic                clock,
  input  logic                reset,
  cycle_count_timer_if.slave  cmd,
  output logic                busy,
  output logic [CNT_W-1:0]    remaining,
  output logic                pending,
  output logic                expired,
  output logic [EXP_W-1:0]    expiry_total
);

  ccount_state_e    state, state_nxt;
  logic [CNT_W-1:0] rem_nxt, pend_cnt, pcnt_nxt;
  logic             pend_nxt, exp_nxt;
  logic [EXP_W-1:0] tot_nxt;
  logic             accept;

  assign cmd.cmd_ready = !pending && !cmd.cmd_abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign busy          = (state == COUNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      pending      <= 1'b0;
      pend_cnt     <= '0;
      expired      <= 1'b0;
      expiry_total <= '0;
    end else begin
      state        <= state_nxt;
      remaining    <= rem_nxt;
      pending      <= pend_nxt;
      pend_cnt     <= pcnt_nxt;
      expired      <= exp_nxt;
      expiry_total <= tot_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    pend_nxt  = pending;
    pcnt_nxt  = pend_cnt;
    exp_nxt   = 1'b0;
    tot_nxt   = expiry_total;
    if (cmd.cmd_abort) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
      pend_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem_nxt   = cmd.cmd_count;
            state_nxt = COUNT;
          end
        end
        COUNT: begin
          // A loaded count of 0 behaves like 1: it completes on the next edge.
          if (remaining <= CNT_W'(1)) begin
            exp_nxt = 1'b1;
            rem_nxt = '0;
            if (expiry_total != '1) tot_nxt = expiry_total + EXP_W'(1);
            if (pending) begin
              rem_nxt  = pend_cnt;
              pend_nxt = 1'b0;
            end else if (accept) begin
              rem_nxt = cmd.cmd_count;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            rem_nxt = remaining - CNT_W'(1);
            if (accept) begin
              pend_nxt = 1'b1;
              pcnt_nxt = cmd.cmd_count;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_count_timer.sv
// Directed and random stimulus against a deadline-based reference model.
module tb_cycle_count_timer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cycle_count_timer_if #(.CNT_W(32)) ifa ();
  cycle_count_timer_if #(.CNT_W(32)) ifb ();

  logic        busy_a, pend_a, exp_a, busy_b, pend_b, exp_b;
  logic [31:0] rem_a, rem_b;
  logic [15:0] tot_a;
  logic [1:0]  tot_b;

  cycle_count_timer #(.CNT_W(32), .EXP_W(16)) dut (
    .clock(clock), .reset(reset), .cmd(ifa.slave), .busy(busy_a),
    .remaining(rem_a), .pending(pend_a), .expired(exp_a), .expiry_total(tot_a));

  cycle_count_timer #(.CNT_W(32), .EXP_W(2)) dut_sat (
    .clock(clock), .reset(reset), .cmd(ifb.slave), .busy(busy_b),
    .remaining(rem_b), .pending(pend_b), .expired(exp_b), .expiry_total(tot_b));

  int errors = 0;
  int checks = 0;

  // Model: an active count is a deadline edge; the pending slot is a flag+value.
  longint e = 0;
  bit     m_busy, m_pend, m_expired;
  logic [31:0] m_pcnt, m_lval;
  longint m_ledge, m_exp_at;
  int     m_tot, m_tot2;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at edge %0d: got %0h want %0h", tag, e, obs, expv);
    end
  endtask

  task automatic m_load(logic [31:0] n);
    m_busy   = 1'b1;
    m_lval   = n;
    m_ledge  = e;
    m_exp_at = e + ((n == 0) ? 1 : longint'(n));
  endtask

  function automatic logic [31:0] m_rem();
    if (!m_busy) return 32'd0;
    if (e == m_ledge) return m_lval;
    return 32'(m_exp_at - e);
  endfunction

  task automatic step(bit r, bit v, logic [31:0] c, bit a);
    bit acc, done;
    @(negedge clock);
    reset = r;
    ifa.cmd_valid = v; ifa.cmd_count = c; ifa.cmd_abort = a;
    ifb.cmd_valid = v; ifb.cmd_count = c; ifb.cmd_abort = a;
    #1;
    chk("cmd_ready", 64'(ifa.cmd_ready), 64'(!m_pend && !a));
    @(posedge clock);
    e++;
    if (r) begin
      m_busy = 0; m_pend = 0; m_expired = 0; m_tot = 0; m_tot2 = 0;
    end else if (a) begin
      m_busy = 0; m_pend = 0; m_expired = 0;
    end else begin
      acc  = v && !m_pend;
      done = m_busy && (e == m_exp_at);
      m_expired = done;
      if (done) begin
        if (m_tot < 65535) m_tot++;
        if (m_tot2 < 3) m_tot2++;
        if (m_pend) begin
          m_load(m_pcnt);
          m_pend = 0;
        end else if (acc) m_load(c);
        else m_busy = 0;
      end else if (m_busy) begin
        if (acc) begin
          m_pend = 1; m_pcnt = c;
        end
      end else if (acc) m_load(c);
    end
    #1;
    chk("busy", 64'(busy_a), 64'(m_busy));
    chk("remaining", 64'(rem_a), 64'(m_rem()));
    chk("pending", 64'(pend_a), 64'(m_pend));
    chk("expired", 64'(exp_a), 64'(m_expired));
    chk("expiry_total", 64'(tot_a), 64'(m_tot));
    chk("expiry_total_w2", 64'(tot_b), 64'(m_tot2));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'd0, 0);
  endtask

  initial begin
    reset = 1'b1;
    ifa.cmd_valid = 0; ifa.cmd_count = '0; ifa.cmd_abort = 0;
    ifb.cmd_valid = 0; ifb.cmd_count = '0; ifb.cmd_abort = 0;
    step(1, 0, 32'd0, 0);
    step(1, 0, 32'd0, 0);
    idle(1);

    // N=5 from idle
    step(0, 1, 32'd5, 0);
    idle(6);
    chk("total_after_n5", 64'(tot_a), 64'd1);

    // N=0 and N=1 both complete one edge later
    step(0, 1, 32'd0, 0);
    idle(2);
    step(0, 1, 32'd1, 0);
    idle(2);

    // N=3 active, N=4 queued, back-to-back completions
    step(0, 1, 32'd3, 0);
    step(0, 1, 32'd4, 0);
    step(0, 1, 32'd8, 0);
    idle(6);

    // abort with active + pending, valid held during abort
    step(0, 1, 32'd10, 0);
    step(0, 1, 32'd6, 0);
    idle(2);
    step(0, 1, 32'd9, 1);
    idle(2);

    // direct load on the expiry edge
    step(0, 1, 32'd3, 0);
    idle(2);
    step(0, 1, 32'd2, 0);
    idle(3);

    // all-ones count loads intact
    step(0, 1, 32'hFFFF_FFFF, 0);
    idle(2);
    step(0, 0, 32'd0, 1);

    // reset mid-count with remaining=7
    step(0, 1, 32'd9, 0);
    idle(2);
    step(1, 0, 32'd0, 0);
    idle(1);

    // saturation of the 2-bit counter
    for (int i = 0; i < 7; i++) step(0, 1, 32'd1, 0);
    idle(2);
    chk("total_w2_sat", 64'(tot_b), 64'd3);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
           32'($urandom_range(0, 6)), ($urandom_range(0, 24) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
